instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instruction_fetch.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// jump opcodes recognised by the pre-decoder and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,  // request outstanding at the fetch address
    ST_HOLD   = 2'd1,  // instruction held for the CPU
    ST_SQUASH = 2'd2   // outstanding response will be thrown away
  } state_t;

  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_JAL           = 6'b000011;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True for the two absolute-jump opcodes whose target is known at fetch.
  function automatic logic is_jump(input logic [5:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, holds one
// instruction for the CPU, pre-decodes J/JAL and honours CPU redirects.
//
// Memory handshake: a transfer completes on the rising edge where imemReq
// and imemReady are both 1; imemAddr stays stable while imemReq is 1.
// CPU handshake: instrValid/instruction/pc/pcPlus4 are stable until the
// rising edge where instrValid and instrAccept are both 1.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        instrValid,
  input  logic        instrAccept,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output state_t      fsmState
);

  // A non-aligned RESET_PC is forced onto a word boundary.
  localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  state_t      state;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] fetch_pc;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc_plus4;
  logic [31:0] next_fetch_pc;
  logic        xfer;

  // Next-address arithmetic: aligned redirect target, sequential and jump paths.
  assign redirect_pc    = redirectTarget & 32'hFFFF_FFFC;
  assign fetch_pc_plus4 = fetch_pc + 32'd4;
  assign next_fetch_pc  = is_jump(imemData[31:26])
                        ? {fetch_pc_plus4[31:28], imemData[25:0], 2'b00}
                        : fetch_pc_plus4;
  assign xfer           = req_q && imemReady;

  // Fetch FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_REQ;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC_W;
      fetch_pc   <= RESET_PC_W;
      instr_q    <= 32'd0;
      pc_q       <= RESET_PC_W;
      pc_plus4_q <= RESET_PC_W + 32'd4;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (!req_q) begin
            // First cycle out of reset: start the request.
            req_q <= 1'b1;
            if (redirectValid) begin
              fetch_pc <= redirect_pc;
              addr_q   <= redirect_pc;
            end
          end else if (redirectValid) begin
            // Redirect beats pre-decode; a completing response is dropped.
            fetch_pc <= redirect_pc;
            if (imemReady) begin
              addr_q <= redirect_pc;
            end else begin
              state <= ST_SQUASH;
            end
          end else if (xfer) begin
            instr_q    <= imemData;
            pc_q       <= fetch_pc;
            pc_plus4_q <= fetch_pc_plus4;
            valid_q    <= 1'b1;
            fetch_pc   <= next_fetch_pc;
            addr_q     <= next_fetch_pc;
            req_q      <= 1'b0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirectValid) begin
            valid_q  <= 1'b0;
            fetch_pc <= redirect_pc;
            addr_q   <= redirect_pc;
            req_q    <= 1'b1;
            state    <= ST_REQ;
          end else if (instrAccept) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_SQUASH: begin
          // Keep requesting the old address until it answers, then move on.
          if (redirectValid) begin
            fetch_pc <= redirect_pc;
          end
          if (imemReady) begin
            addr_q <= redirectValid ? redirect_pc : fetch_pc;
            state  <= ST_REQ;
          end
        end
        default: begin
          state   <= ST_REQ;
          req_q   <= 1'b1;
          addr_q  <= fetch_pc;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imemReq     = req_q;
  assign imemAddr    = addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pcPlus4     = pc_plus4_q;
  assign instrValid  = valid_q;
  assign fsmState    = state;

endmodule
